// File: rtl/forwarding.sv
// Operand forwarding and load-use stall unit for a 5-stage pipeline.
// Optional macro FWD_R0_GUARD_EN makes register 0 invisible to forwarding and hazard detection.
module forwarding #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fw_if_id_stall,
    input  logic [REG_W-1:0]  id_fw_regdest,
    input  logic              id_fw_load,
    input  logic [REG_W-1:0]  id_fw_addra,
    input  logic [REG_W-1:0]  id_fw_addrb,
    input  logic [DATA_W-1:0] id_fw_rega,
    input  logic [DATA_W-1:0] id_fw_regb,
    output logic [DATA_W-1:0] fw_id_rega,
    output logic [DATA_W-1:0] fw_id_regb,
    input  logic [DATA_W-1:0] ex_fw_wbvalue,
    input  logic              ex_fw_writereg,
    input  logic [DATA_W-1:0] mem_fw_wbvalue,
    input  logic              mem_fw_writereg,
    input  logic [DATA_W-1:0] wb_fw_wbvalue,
    input  logic              wb_fw_writereg
);

    logic              ex_valid_q,  ex_valid_d;
    logic [REG_W-1:0]  ex_dest_q,   ex_dest_d;
    logic              ex_load_q,   ex_load_d;
    logic              mem_valid_q, mem_valid_d;
    logic [REG_W-1:0]  mem_dest_q,  mem_dest_d;
    logic              mem_load_q,  mem_load_d;
    logic              wb_valid_q,  wb_valid_d;
    logic [REG_W-1:0]  wb_dest_q,   wb_dest_d;
    logic              wb_load_q,   wb_load_d;
    logic [DATA_W-1:0] rega_q,      rega_d;
    logic [DATA_W-1:0] regb_q,      regb_d;
    logic              stall_q,     stall_d;

    logic addra_ok, addrb_ok;
    logic ex_match_a, mem_match_a, wb_match_a;
    logic ex_match_b, mem_match_b, wb_match_b;
    logic hazard;

`ifdef FWD_R0_GUARD_EN
    assign addra_ok = (id_fw_addra != '0);
    assign addrb_ok = (id_fw_addrb != '0);
`else
    assign addra_ok = 1'b1;
    assign addrb_ok = 1'b1;
`endif

    assign ex_match_a  = addra_ok && ex_valid_q  && (ex_dest_q  == id_fw_addra) && ex_fw_writereg;
    assign mem_match_a = addra_ok && mem_valid_q && (mem_dest_q == id_fw_addra) && mem_fw_writereg;
    assign wb_match_a  = addra_ok && wb_valid_q  && (wb_dest_q  == id_fw_addra) && wb_fw_writereg;
    assign ex_match_b  = addrb_ok && ex_valid_q  && (ex_dest_q  == id_fw_addrb) && ex_fw_writereg;
    assign mem_match_b = addrb_ok && mem_valid_q && (mem_dest_q == id_fw_addrb) && mem_fw_writereg;
    assign wb_match_b  = addrb_ok && wb_valid_q  && (wb_dest_q  == id_fw_addrb) && wb_fw_writereg;

    // A load still in EX cannot supply its data yet; writereg is deliberately ignored here.
    assign hazard = !stall_q && ex_valid_q && ex_load_q &&
                    ((addra_ok && (ex_dest_q == id_fw_addra)) ||
                     (addrb_ok && (ex_dest_q == id_fw_addrb)));

    always_comb begin
        mem_valid_d = ex_valid_q;
        mem_dest_d  = ex_dest_q;
        mem_load_d  = ex_load_q;
        wb_valid_d  = mem_valid_q;
        wb_dest_d   = mem_dest_q;
        wb_load_d   = mem_load_q;
        ex_valid_d  = 1'b0;
        ex_dest_d   = '0;
        ex_load_d   = 1'b0;
        rega_d      = '0;
        regb_d      = '0;
        stall_d     = 1'b0;

        if (hazard) begin
            stall_d = 1'b1;
        end else begin
            ex_valid_d = 1'b1;
            ex_dest_d  = id_fw_regdest;
            ex_load_d  = id_fw_load;

            if (ex_match_a)       rega_d = ex_fw_wbvalue;
            else if (mem_match_a) rega_d = mem_fw_wbvalue;
            else if (wb_match_a)  rega_d = wb_fw_wbvalue;
            else                  rega_d = id_fw_rega;

            if (ex_match_b)       regb_d = ex_fw_wbvalue;
            else if (mem_match_b) regb_d = mem_fw_wbvalue;
            else if (wb_match_b)  regb_d = wb_fw_wbvalue;
            else                  regb_d = id_fw_regb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_dest_q   <= '0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= '0;
            mem_load_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= '0;
            wb_load_q   <= 1'b0;
            rega_q      <= '0;
            regb_q      <= '0;
            stall_q     <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_dest_q   <= ex_dest_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
            mem_load_q  <= mem_load_d;
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
            wb_load_q   <= wb_load_d;
            rega_q      <= rega_d;
            regb_q      <= regb_d;
            stall_q     <= stall_d;
        end
    end

    assign fw_id_rega     = rega_q;
    assign fw_id_regb     = regb_q;
    assign fw_if_id_stall = stall_q;

    // The WB-slot load flag is carried for history completeness only.
    logic unused_wb_load;
    assign unused_wb_load = wb_load_q;

endmodule

// File: tb/tb_forwarding.sv
// Directed self-checking bench for the forwarding unit.
module tb_forwarding;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              clk;
    logic              rst_n;
    logic              fw_if_id_stall;
    logic [REG_W-1:0]  id_fw_regdest;
    logic              id_fw_load;
    logic [REG_W-1:0]  id_fw_addra;
    logic [REG_W-1:0]  id_fw_addrb;
    logic [DATA_W-1:0] id_fw_rega;
    logic [DATA_W-1:0] id_fw_regb;
    logic [DATA_W-1:0] fw_id_rega;
    logic [DATA_W-1:0] fw_id_regb;
    logic [DATA_W-1:0] ex_fw_wbvalue;
    logic              ex_fw_writereg;
    logic [DATA_W-1:0] mem_fw_wbvalue;
    logic              mem_fw_writereg;
    logic [DATA_W-1:0] wb_fw_wbvalue;
    logic              wb_fw_writereg;

    int errors = 0;
    int checks = 0;

    forwarding #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fw_if_id_stall  (fw_if_id_stall),
        .id_fw_regdest   (id_fw_regdest),
        .id_fw_load      (id_fw_load),
        .id_fw_addra     (id_fw_addra),
        .id_fw_addrb     (id_fw_addrb),
        .id_fw_rega      (id_fw_rega),
        .id_fw_regb      (id_fw_regb),
        .fw_id_rega      (fw_id_rega),
        .fw_id_regb      (fw_id_regb),
        .ex_fw_wbvalue   (ex_fw_wbvalue),
        .ex_fw_writereg  (ex_fw_writereg),
        .mem_fw_wbvalue  (mem_fw_wbvalue),
        .mem_fw_writereg (mem_fw_writereg),
        .wb_fw_wbvalue   (wb_fw_wbvalue),
        .wb_fw_writereg  (wb_fw_writereg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one decode instruction and let one rising edge consume it.
    task automatic issue(input int a, input int b, input int d, input bit ld);
        id_fw_addra   = REG_W'(a);
        id_fw_addrb   = REG_W'(b);
        id_fw_regdest = REG_W'(d);
        id_fw_load    = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        issue(1, 2, 3, 0);
        do_reset();
        checks++;
        if (fw_id_rega !== 32'd0 || fw_id_regb !== 32'd0 || fw_if_id_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset: a=%0d b=%0d stall=%0b, want a=0 b=0 stall=0",
                     fw_id_rega, fw_id_regb, fw_if_id_stall);
        end
    endtask

    task automatic test_ex_forward();
        do_reset();
        issue(2, 1, 3, 0);
        issue(3, 1, 2, 0);
        checks++;
        if (fw_id_rega !== 32'd20 || fw_id_regb !== 32'd10 || fw_if_id_stall !== 1'b0) begin
            errors++;
            $display("FAIL ex_forward: a=%0d b=%0d stall=%0b, want a=20 b=10 stall=0",
                     fw_id_rega, fw_id_regb, fw_if_id_stall);
        end
    endtask

    task automatic test_mem_ex_forward();
        do_reset();
        issue(4, 5, 6, 0);
        issue(4, 5, 7, 0);
        checks++;
        if (fw_id_rega !== 32'd10 || fw_id_regb !== 32'd10) begin
            errors++;
            $display("FAIL no_match: a=%0d b=%0d, want a=10 b=10", fw_id_rega, fw_id_regb);
        end
        issue(6, 7, 2, 0);
        checks++;
        if (fw_id_rega !== 32'd30 || fw_id_regb !== 32'd20) begin
            errors++;
            $display("FAIL mem_ex_forward: a=%0d b=%0d, want a=30 b=20", fw_id_rega, fw_id_regb);
        end
    endtask

    task automatic test_wb_forward();
        do_reset();
        issue(1, 5, 2, 0);
        issue(1, 5, 4, 0);
        issue(1, 5, 6, 0);
        issue(4, 2, 3, 0);
        checks++;
        if (fw_id_rega !== 32'd30 || fw_id_regb !== 32'd40) begin
            errors++;
            $display("FAIL mem_wb_forward: a=%0d b=%0d, want a=30 b=40", fw_id_rega, fw_id_regb);
        end
        issue(4, 3, 1, 0);
        checks++;
        if (fw_id_rega !== 32'd40 || fw_id_regb !== 32'd20) begin
            errors++;
            $display("FAIL wb_ex_forward: a=%0d b=%0d, want a=40 b=20", fw_id_rega, fw_id_regb);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 2, 3, 1);
        checks++;
        if (fw_if_id_stall !== 1'b0 || fw_id_rega !== 32'd10) begin
            errors++;
            $display("FAIL load_issue: stall=%0b a=%0d, want stall=0 a=10", fw_if_id_stall, fw_id_rega);
        end
        issue(3, 4, 5, 0);
        checks++;
        if (fw_if_id_stall !== 1'b1 || fw_id_rega !== 32'd0 || fw_id_regb !== 32'd0) begin
            errors++;
            $display("FAIL load_use_bubble: stall=%0b a=%0d b=%0d, want stall=1 a=0 b=0",
                     fw_if_id_stall, fw_id_rega, fw_id_regb);
        end
        issue(3, 4, 5, 0);
        checks++;
        if (fw_if_id_stall !== 1'b0 || fw_id_rega !== 32'd30 || fw_id_regb !== 32'd10) begin
            errors++;
            $display("FAIL load_use_resume: stall=%0b a=%0d b=%0d, want stall=0 a=30 b=10",
                     fw_if_id_stall, fw_id_rega, fw_id_regb);
        end
        issue(5, 1, 6, 0);
        checks++;
        if (fw_id_rega !== 32'd20) begin
            errors++;
            $display("FAIL after_stall_ex: a=%0d, want 20", fw_id_rega);
        end
    endtask

    task automatic test_writereg_gate();
        do_reset();
        issue(1, 2, 7, 0);
        issue(1, 2, 8, 0);
        issue(1, 2, 7, 0);
        ex_fw_writereg = 1'b0;
        issue(7, 7, 9, 0);
        ex_fw_writereg = 1'b1;
        checks++;
        if (fw_id_rega !== 32'd40 || fw_id_regb !== 32'd40) begin
            errors++;
            $display("FAIL writereg_gate: a=%0d b=%0d, want a=40 b=40", fw_id_rega, fw_id_regb);
        end
        issue(7, 8, 1, 0);
        checks++;
        if (fw_id_rega !== 32'd30 || fw_id_regb !== 32'd40) begin
            errors++;
            $display("FAIL mem_over_wb: a=%0d b=%0d, want a=30 b=40", fw_id_rega, fw_id_regb);
        end
    endtask

    task automatic test_back_to_back_loads();
        do_reset();
        issue(1, 2, 3, 1);
        issue(3, 1, 4, 1);
        checks++;
        if (fw_if_id_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stall1: stall=%0b, want 1", fw_if_id_stall);
        end
        issue(3, 1, 4, 1);
        checks++;
        if (fw_if_id_stall !== 1'b0 || fw_id_rega !== 32'd30) begin
            errors++;
            $display("FAIL b2b_resume1: stall=%0b a=%0d, want stall=0 a=30", fw_if_id_stall, fw_id_rega);
        end
        issue(1, 4, 5, 0);
        checks++;
        if (fw_if_id_stall !== 1'b1 || fw_id_regb !== 32'd0) begin
            errors++;
            $display("FAIL b2b_stall2: stall=%0b b=%0d, want stall=1 b=0", fw_if_id_stall, fw_id_regb);
        end
        issue(1, 4, 5, 0);
        checks++;
        if (fw_if_id_stall !== 1'b0 || fw_id_regb !== 32'd30 || fw_id_rega !== 32'd10) begin
            errors++;
            $display("FAIL b2b_resume2: stall=%0b a=%0d b=%0d, want stall=0 a=10 b=30",
                     fw_if_id_stall, fw_id_rega, fw_id_regb);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(1, 2, 3, 1);
        issue(3, 4, 5, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (fw_if_id_stall !== 1'b0 || fw_id_rega !== 32'd0 || fw_id_regb !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_mid_stall: stall=%0b a=%0d b=%0d, want 0 0 0",
                     fw_if_id_stall, fw_id_rega, fw_id_regb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(3, 4, 5, 0);
        checks++;
        if (fw_if_id_stall !== 1'b0 || fw_id_rega !== 32'd10 || fw_id_regb !== 32'd10) begin
            errors++;
            $display("FAIL post_reset_edge: stall=%0b a=%0d b=%0d, want stall=0 a=10 b=10",
                     fw_if_id_stall, fw_id_rega, fw_id_regb);
        end
    endtask

    task automatic test_reg0();
        logic [DATA_W-1:0] exp_fwd;
        logic              exp_stall;
`ifdef FWD_R0_GUARD_EN
        exp_fwd   = 32'd10;
        exp_stall = 1'b0;
`else
        exp_fwd   = 32'd20;
        exp_stall = 1'b1;
`endif
        do_reset();
        issue(1, 2, 0, 0);
        issue(0, 0, 7, 0);
        checks++;
        if (fw_id_rega !== exp_fwd || fw_id_regb !== exp_fwd) begin
            errors++;
            $display("FAIL reg0_forward: a=%0d b=%0d, want %0d", fw_id_rega, fw_id_regb, exp_fwd);
        end
        issue(1, 2, 0, 1);
        issue(0, 1, 7, 0);
        checks++;
        if (fw_if_id_stall !== exp_stall) begin
            errors++;
            $display("FAIL reg0_hazard: stall=%0b, want %0b", fw_if_id_stall, exp_stall);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        id_fw_regdest   = '0;
        id_fw_load      = 1'b0;
        id_fw_addra     = '0;
        id_fw_addrb     = '0;
        id_fw_rega      = 32'd10;
        id_fw_regb      = 32'd10;
        ex_fw_wbvalue   = 32'd20;
        mem_fw_wbvalue  = 32'd30;
        wb_fw_wbvalue   = 32'd40;
        ex_fw_writereg  = 1'b1;
        mem_fw_writereg = 1'b1;
        wb_fw_writereg  = 1'b1;
        #12;
        rst_n = 1'b1;

        test_reset();
        test_ex_forward();
        test_mem_ex_forward();
        test_wb_forward();
        test_load_use();
        test_writereg_gate();
        test_back_to_back_loads();
        test_reset_mid_stall();
        test_reg0();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
